lvds_fpd_serializer: RTL
========================

# lvds_fpd_serializer

7:1 FPD-Link (LVDS) transmitter core for the laptop panel. It runs on the 336 MHz bit clock from the `lvdsClk` PLL, which is 7× the 48 MHz pixel rate. It accepts one RGB666 pixel plus sync/enable per 7 bit-clocks over a valid/ready handshake, packs it into three 7-bit data-lane words and the clock-lane pattern, and shifts them out MSB-first to the output buffers. When the upstream timing generator fails to supply a pixel in time, the block substitutes a blanking word and counts the underflow.

## Interface
- HS_IDLE, 1'b0: HS level sent in a substituted (underflow/disabled) blanking word
- VS_IDLE, 1'b0: VS level sent in a substituted blanking word
- UF_WIDTH, 16: width of the saturating underflow counter
- pllOutClock  in  1  336 MHz bit clock, the single clock; all logic on rising edge
- resetN  in  1  synchronous, active-low reset
- txEnable  in  1  1 = transmit; 0 = lanes idle low, phase held
- pixelValid  in  1  upstream pixel present
- pixelReady  out  1  block accepts pixel this cycle
- pixelR, pixelG, pixelB  in  6 each  RGB666 data
- pixelHs, pixelVs, pixelDe  in  1 each  sync/data-enable for the pixel
- lane0, lane1, lane2  out  1 each  serial data lanes, to OB pads
- laneClk  out  1  serial clock lane
- underflowCount  out  UF_WIDTH  saturating count of substituted words
- underflowFlag  out  1  sticky: at least one underflow since reset

## Operation
- Phase counter `phase`, 0..6, advances by 1 each cycle while txEnable=1, and wraps 6→0.
- pixelReady = txEnable & (phase==6). This signal is combinational from registers only and never depends on pixelValid.
- Load edge: the edge where phase goes 6→0. At this edge all four shift registers (7 bits each) load:
  - If pixelValid=1 (accept), lane words are built from the pixel.
  - Otherwise a blanking word is built from R=G=B=0, DE=0, HS=HS_IDLE, VS=VS_IDLE. underflowCount increments and saturates at all-ones, and underflowFlag is set.
- Word packing, bit 6 transmitted first:
  - lane0 = {G0,R5,R4,R3,R2,R1,R0}
  - lane1 = {B1,B0,G5,G4,G3,G2,G1}
  - lane2 = {DE,VS,HS,B5,B4,B3,B2}
  - laneClk = 7'b1100011
- All other enabled edges shift each register left by 1. Each serial output is the registered bit 6.
- txEnable=0:
  - phase forced to 0, shift registers cleared, and all lane outputs 0 on the next edge.
  - pixelReady=0.
  - No underflow is counted.
  - Counters and flag are held.
- txEnable 0→1: phase counts from 0. The first load edge is the 7th enabled edge, and lanes output 0 until then.
- resetN=0 (sampled at an edge) overrides everything, including mid-word. The block restarts exactly as after power-up.

## Timing
- Reset values: phase=0, all shift regs 0, lane0/1/2=0, laneClk=0, pixelReady=0, underflowCount=0, underflowFlag=0.
- Throughput: one pixel per 7 cycles, exactly. Never more, never fewer while enabled.
- Latency: the pixel is accepted at load edge E. Its bit 6 is visible on the lanes in the cycle after E, and bit 0 in the cycle after E+6.
- Between load edges the lane outputs present bits 6,5,4,3,2,1,0 in consecutive cycles. The laneClk sequence per word is 1,1,0,0,0,1,1.
- Handshake: the transfer occurs only when pixelValid & pixelReady at a rising edge. Pixel data must be stable in that cycle only. pixelValid in other phases is ignored and consumes nothing.
- Underflow counter saturation: at value 2^UF_WIDTH−1 it stays there. The flag clears only on reset.
- Simultaneous txEnable falling at the phase-6 edge: disable wins. There is no load, no accept and no underflow.

## Test plan
- Reset, then txEnable=1, pixelValid held 1 with R=6'h2A, G=6'h15, B=6'h3F, HS=1, VS=0, DE=1:
  - pixelReady pulses every 7 cycles, first on the 7th edge after enable.
  - lane0 serial=1101010, lane1=1101010, lane2=1011111, laneClk=1100011, repeating.
- Back-to-back distinct pixels R=1,2,3,… for 10 words: the decoded lane0 words are the matching sequence with no drop or duplicate. The accept-to-first-bit latency is 1 cycle.
- pixelValid low for 3 load edges with HS_IDLE=1, VS_IDLE=0:
  - Three blanking words are sent, with lane2 = 0010000.
  - underflowCount=3 and underflowFlag=1.
  - The next valid pixel is sent normally.
- Force 65540 consecutive underflows: underflowCount saturates at 16'hFFFF and stays there.
- Drop txEnable at phase 3 mid-word:
  - Lanes go 0 on the next edge and pixelReady stays 0.
  - On re-enable, the first load occurs on the 7th edge and the pattern resumes aligned.
- Assert resetN=0 for one cycle at phase 4 while transmitting:
  - All outputs and counters return to 0.
  - Restart timing is identical to the power-up case.

Source files
------------

// File: rtl/lvds_fpd_serializer.sv
// 7:1 FPD-Link LVDS transmitter: packs one RGB666 pixel plus sync/enable into
// three data-lane words and a clock-lane word, shifted out MSB-first.
module lvds_fpd_serializer #(
  parameter logic        HS_IDLE  = 1'b0,
  parameter logic        VS_IDLE  = 1'b0,
  parameter int unsigned UF_WIDTH = 16
) (
  input  logic                pllOutClock,
  input  logic                resetN,
  input  logic                txEnable,
  input  logic                pixelValid,
  output logic                pixelReady,
  input  logic [5:0]          pixelR,
  input  logic [5:0]          pixelG,
  input  logic [5:0]          pixelB,
  input  logic                pixelHs,
  input  logic                pixelVs,
  input  logic                pixelDe,
  output logic                lane0,
  output logic                lane1,
  output logic                lane2,
  output logic                laneClk,
  output logic [UF_WIDTH-1:0] underflowCount,
  output logic                underflowFlag
);

  localparam logic [6:0] CLK_WORD  = 7'b1100011;
  localparam logic [2:0] LAST_PHASE = 3'd6;

  logic [2:0] phase;
  logic [6:0] sr0, sr1, sr2, src;
  logic [6:0] word0, word1, word2;
  logic [5:0] r, g, b;
  logic       hs, vs, de;

  // Ready is only a function of phase and enable, so a disable at the
  // phase-6 edge suppresses the load, the accept and the underflow together.
  assign pixelReady = txEnable & (phase == LAST_PHASE);

  always_comb begin
    r  = '0;
    g  = '0;
    b  = '0;
    hs = HS_IDLE;
    vs = VS_IDLE;
    de = 1'b0;
    if (pixelValid) begin
      r  = pixelR;
      g  = pixelG;
      b  = pixelB;
      hs = pixelHs;
      vs = pixelVs;
      de = pixelDe;
    end
    word0 = {g[0], r};
    word1 = {b[1:0], g[5:1]};
    word2 = {de, vs, hs, b[5:2]};
  end

  always_ff @(posedge pllOutClock) begin
    if (!resetN) begin
      phase          <= '0;
      sr0            <= '0;
      sr1            <= '0;
      sr2            <= '0;
      src            <= '0;
      underflowCount <= '0;
      underflowFlag  <= 1'b0;
    end else if (!txEnable) begin
      phase <= '0;
      sr0   <= '0;
      sr1   <= '0;
      sr2   <= '0;
      src   <= '0;
    end else if (phase == LAST_PHASE) begin
      phase <= '0;
      sr0   <= word0;
      sr1   <= word1;
      sr2   <= word2;
      src   <= CLK_WORD;
      if (!pixelValid) begin
        underflowFlag <= 1'b1;
        if (underflowCount != '1)
          underflowCount <= underflowCount + 1'b1;
      end
    end else begin
      phase <= phase + 3'd1;
      sr0   <= {sr0[5:0], 1'b0};
      sr1   <= {sr1[5:0], 1'b0};
      sr2   <= {sr2[5:0], 1'b0};
      src   <= {src[5:0], 1'b0};
    end
  end

  assign lane0   = sr0[6];
  assign lane1   = sr1[6];
  assign lane2   = sr2[6];
  assign laneClk = src[6];

endmodule
